if_fetch: RTL and testbench

Instruction fetch stage that supplies the decode stage with `inst` / `inst_addr`. It holds the architectural PC and issues one word request at a time to instruction memory over a req/gnt/rvalid handshake. Each returned word is registered and presented to decode with a valid/ready handshake. Branch and jump redirects from execute flush the held instruction and kill any in-flight response.

---
 rtl/if_fetch.sv | 120 ++++++++++++
 tb/tb_if_fetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request at a time, a registered instruction
// handed to decode over valid/ready, and execute redirects that flush and kill in-flight data.
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        jmp_ena,
  input  logic [63:0] jmp_target,
  input  logic        id_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_addr,
  output logic [63:0] fetch_cnt
);

  typedef enum logic [0:0] {StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] inst_addr_q, inst_addr_d;
  logic [63:0] fetch_cnt_q, fetch_cnt_d;

  logic accept;
  logic fire;

  assign accept = inst_valid_q & id_ready;

  // A new request only goes out once the held instruction is gone or leaving this cycle.
  assign imem_req  = ~rst & (state_q == StReq) & (~inst_valid_q | id_ready);
  assign imem_addr = pc_q;
  assign fire      = imem_req & imem_gnt;

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_addr  = inst_addr_q;
  assign fetch_cnt  = fetch_cnt_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    fetch_cnt_d  = fetch_cnt_q;

    if (accept) begin
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
      fetch_cnt_d  = fetch_cnt_q + 64'd1;
    end

    case (state_q)
      StReq: begin
        if (fire) begin
          state_d  = StWait;
          req_pc_d = pc_q;
          pc_d     = pc_q + 64'd4;
          kill_d   = jmp_ena;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          state_d = StReq;
          kill_d  = 1'b0;
          if (~kill_q & ~jmp_ena) begin
            inst_valid_d = 1'b1;
            inst_d       = imem_rdata;
            inst_addr_d  = req_pc_q;
          end
        end else if (jmp_ena) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = StReq;
    endcase

    // Redirect wins over the sequential PC and any freshly loaded word.
    if (jmp_ena) begin
      pc_d         = jmp_target & ~64'd3;
      inst_valid_d = 1'b0;
      inst_d       = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      kill_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_addr_q  <= 64'd0;
      fetch_cnt_q  <= 64'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: transaction-level model with a pending-request queue and a simple
// latency-programmable instruction memory, plus hand-computed literal checks.
module tb_if_fetch;

  localparam logic [63:0] RstPc = 64'h0000_0000_8000_0000;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        jmp_ena;
  logic [63:0] jmp_target;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  logic [63:0] fetch_cnt;

  if_fetch dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .jmp_ena    (jmp_ena),
    .jmp_target (jmp_target),
    .id_ready   (id_ready),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_addr  (inst_addr),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus knobs, applied at the start of each cycle.
  bit          rst_v, gnt_v, idr_v, jmp_v, stray_v;
  logic [63:0] tgt_v;
  int          lat_v;

  // Instruction memory: one response lat_v cycles after a grant.
  bit          mem_busy;
  int          mem_cnt;
  logic [63:0] mem_addr;

  // Model: requests in flight are a queue; a redirect marks them all dead.
  typedef struct {
    logic [63:0] addr;
    bit          dead;
  } pend_t;
  pend_t       pend[$];
  logic [63:0] m_pc, m_addr, m_cnt;
  logic        m_valid;
  logic [31:0] m_inst;
  bit          checking;

  logic        s_req;
  logic [63:0] s_addr;
  int          req_seen;
  int          n_tests, n_fail;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h8050_0093;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    pend_t p;
    bit    fire, got;
    if (rst_v) begin
      m_pc     = RstPc;
      m_valid  = 1'b0;
      m_inst   = Nop;
      m_addr   = 64'd0;
      m_cnt    = 64'd0;
      mem_busy = 1'b0;
      pend.delete();
      checking = 1'b1;
    end else begin
      fire = (pend.size() == 0) && (!m_valid || idr_v) && gnt_v;
      got  = (pend.size() != 0) && (imem_rvalid === 1'b1);
      if (m_valid && idr_v) begin
        m_cnt   = m_cnt + 64'd1;
        m_valid = 1'b0;
        m_inst  = Nop;
      end
      if (got) begin
        p = pend.pop_front();
        if (!p.dead && !jmp_v) begin
          m_valid = 1'b1;
          m_inst  = mem_word(p.addr);
          m_addr  = p.addr;
        end
      end
      if (mem_busy) begin
        if (mem_cnt == 1) mem_busy = 1'b0;
        else mem_cnt--;
      end
      if (fire) begin
        pend.push_back('{m_pc, jmp_v});
        mem_busy = 1'b1;
        mem_cnt  = lat_v;
        mem_addr = m_pc;
        m_pc     = m_pc + 64'd4;
      end
      if (jmp_v) begin
        foreach (pend[i]) pend[i].dead = 1'b1;
        m_valid = 1'b0;
        m_inst  = Nop;
        m_pc    = tgt_v & ~64'd3;
      end
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, step the model at the
  // posedge, check registered outputs at the following negedge.
  task automatic tick();
    rst        = rst_v;
    imem_gnt   = gnt_v;
    id_ready   = idr_v;
    jmp_ena    = jmp_v;
    jmp_target = tgt_v;
    if (mem_busy && mem_cnt == 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end else if (stray_v) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    if (s_req === 1'b1) req_seen++;
    if (checking) begin
      chk("imem_req", {63'd0, imem_req},
          {63'd0, !rst_v && pend.size() == 0 && (!m_valid || idr_v)});
      chk("imem_addr", imem_addr, m_pc);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (checking) begin
      chk("inst_valid", {63'd0, inst_valid}, {63'd0, m_valid});
      chk("inst", {32'd0, inst}, {32'd0, m_inst});
      if (m_valid) chk("inst_addr", inst_addr, m_addr);
      chk("fetch_cnt", fetch_cnt, m_cnt);
    end
    jmp_v   = 1'b0;
    stray_v = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int rs;
    rst_v = 1'b1; gnt_v = 1'b0; idr_v = 1'b0; jmp_v = 1'b0; stray_v = 1'b0;
    tgt_v = 64'd0; lat_v = 1;
    rst = 1'b1; imem_gnt = 1'b0; id_ready = 1'b0; jmp_ena = 1'b0; jmp_target = 64'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    @(negedge clk);
    ticks(2);

    // Reset release, grant always, 1-cycle memory, decode ready.
    rst_v = 1'b0; gnt_v = 1'b1; idr_v = 1'b1; lat_v = 1;
    tick();
    chk("first_req", {63'd0, s_req}, 64'd1);
    chk("first_addr", s_addr, 64'h8000_0000);
    tick();
    chk("first_inst", {32'd0, inst}, 64'h0050_0093);
    chk("first_inst_addr", inst_addr, 64'h8000_0000);
    tick();
    chk("second_addr", s_addr, 64'h8000_0004);
    chk("cnt_after_accept", fetch_cnt, 64'd1);

    // Backpressure: word at 0x80000004 held for 5 cycles with no new request.
    idr_v = 1'b0;
    tick();
    req_seen = 0;
    ticks(5);
    chk("bp_no_req", 64'(req_seen), 64'd0);
    chk("bp_inst", {32'd0, inst}, 64'h0050_0097);
    chk("bp_inst_addr", inst_addr, 64'h8000_0004);
    chk("bp_cnt", fetch_cnt, 64'd1);

    // Redirect while waiting on a 3-cycle response.
    idr_v = 1'b1; lat_v = 3;
    ticks(2);
    jmp_v = 1'b1; tgt_v = 64'h8000_0102;
    tick();
    lat_v = 1;
    tick();
    chk("killed_not_valid", {63'd0, inst_valid}, 64'd0);
    tick();
    chk("redir_req", {63'd0, s_req}, 64'd1);
    chk("redir_addr", s_addr, 64'h8000_0100);
    tick();
    chk("redir_inst", {32'd0, inst}, 64'h0050_0193);
    chk("redir_inst_addr", inst_addr, 64'h8000_0100);

    // Redirect in the same cycle as a grant, with an instruction held.
    jmp_v = 1'b1; tgt_v = 64'h8000_0200;
    tick();
    chk("jg_flush_valid", {63'd0, inst_valid}, 64'd0);
    chk("jg_flush_inst", {32'd0, inst}, {32'd0, Nop});
    chk("jg_cnt", fetch_cnt, 64'd3);
    tick();
    chk("jg_drop", {63'd0, inst_valid}, 64'd0);
    idr_v = 1'b0;
    tick();
    chk("jg_addr", s_addr, 64'h8000_0200);
    tick();
    chk("jg_inst", {32'd0, inst}, 64'h0050_0293);

    // Redirect in REQ with no grant (request gated by backpressure), stray rvalid ignored.
    jmp_v = 1'b1; tgt_v = 64'h8000_0301; stray_v = 1'b1;
    tick();
    chk("jn_flush_valid", {63'd0, inst_valid}, 64'd0);
    chk("jn_flush_inst", {32'd0, inst}, {32'd0, Nop});
    tick();
    chk("jn_addr", s_addr, 64'h8000_0300);
    tick();

    // Reset while an instruction is held.
    rst_v = 1'b1;
    tick();
    chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'h0000_0013);
    chk("rst_cnt", fetch_cnt, 64'd0);
    chk("rst_addr", imem_addr, 64'h8000_0000);

    // Reset while waiting on a response.
    rst_v = 1'b0; idr_v = 1'b1; lat_v = 3;
    ticks(2);
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0; lat_v = 1;
    tick();
    chk("post_rst_req", {63'd0, s_req}, 64'd1);
    chk("post_rst_addr", s_addr, 64'h8000_0000);

    // Mixed traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      rs    = $urandom_range(0, 99);
      gnt_v = ($urandom_range(0, 3) != 0);
      idr_v = ($urandom_range(0, 2) != 0);
      lat_v = $urandom_range(1, 3);
      jmp_v = (rs < 8);
      tgt_v = {32'h0, $urandom};
      rst_v = (rs == 99);
      tick();
    end
    rst_v = 1'b0;
    ticks(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
